// File: rtl/ahb_addr_filter_slv_if.sv
// ahb_addr_filter_slv_if: AHB-lite slave bus plus the downstream single-beat req/ack port.
interface ahb_addr_filter_slv_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [1:0]            htrans;
    logic [2:0]            hburst;
    logic [2:0]            hsize;
    logic                  hwrite;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [1:0]            hresp;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  dn_req;
    logic                  dn_we;
    logic [ADDR_WIDTH-1:0] dn_addr;
    logic [DATA_WIDTH-1:0] dn_wdata;
    logic [3:0]            dn_be;
    logic                  dn_ack;
    logic [DATA_WIDTH-1:0] dn_rdata;
    logic                  dn_err;
    modport slave (
        input  hsel, htrans, hburst, hsize, hwrite, haddr, hwdata, dn_ack, dn_rdata, dn_err,
        output hready, hresp, hrdata, dn_req, dn_we, dn_addr, dn_wdata, dn_be
    );
    modport master (
        output hsel, htrans, hburst, hsize, hwrite, haddr, hwdata, dn_ack, dn_rdata, dn_err,
        input  hready, hresp, hrdata, dn_req, dn_we, dn_addr, dn_wdata, dn_be
    );
endinterface

// File: rtl/ahb_addr_filter_slv.sv
// ahb_addr_filter_slv: AHB-lite slave that window/alignment-filters transfers onto a req/ack port.
// Define ADDR_FILTER_STATS_EN to add saturating stat_pass/stat_block counters.
module ahb_addr_filter_slv #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WIN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          hclk,
    input  logic                          hreset,
    ahb_addr_filter_slv_if.slave          bus,
    input  logic [NUM_WIN*ADDR_WIDTH-1:0] cfg_base,
    input  logic [NUM_WIN*ADDR_WIDTH-1:0] cfg_mask,
    input  logic [NUM_WIN-1:0]            cfg_en
`ifdef ADDR_FILTER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]          stat_pass,
    output logic [CNT_WIDTH-1:0]          stat_block
`endif
);
    typedef enum logic [2:0] {IDLE, CAPT, REQ, RESP, ERR1, ERR2} state_t;
    localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;
    localparam int unused_data_width = DATA_WIDTH;
    state_t     state;
    logic       hit, misaligned, pass, capture;
    logic [3:0] be;
    logic       unused;
    assign unused = ^{bus.hburst, bus.htrans[0]};
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_WIN; i++)
            hit = hit | (cfg_en[i] & ((bus.haddr & cfg_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                                      (cfg_base[i*ADDR_WIDTH +: ADDR_WIDTH] & cfg_mask[i*ADDR_WIDTH +: ADDR_WIDTH])));
    end
    assign misaligned = (bus.hsize > 3'd2) | ((bus.hsize == 3'd1) & bus.haddr[0]) |
                        ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00));
    assign pass       = hit & ~misaligned;
    assign capture    = bus.hsel & bus.hready & bus.htrans[1];
    assign be         = (bus.hsize == 3'd0) ? 4'b0001 << bus.haddr[1:0] :
                        (bus.hsize == 3'd1) ? (bus.haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // hready is registered, so a capture can only happen in IDLE, RESP or ERR2
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state        <= IDLE;
            bus.hready   <= 1'b1;
            bus.hresp    <= OKAY;
            bus.hrdata   <= '0;
            bus.dn_req   <= 1'b0;
            bus.dn_we    <= 1'b0;
            bus.dn_addr  <= '0;
            bus.dn_wdata <= '0;
            bus.dn_be    <= '0;
        end else begin
            case (state)
                IDLE, RESP, ERR2: begin
                    state      <= capture ? (pass ? CAPT : ERR1) : IDLE;
                    bus.hready <= ~capture;
                    bus.hresp  <= (capture & ~pass) ? ERROR : OKAY;
                    if (capture & pass) begin
                        bus.dn_addr <= bus.haddr;
                        bus.dn_we   <= bus.hwrite;
                        bus.dn_be   <= be;
                    end
                end
                CAPT: begin
                    state        <= REQ;
                    bus.dn_req   <= 1'b1;
                    bus.dn_wdata <= bus.hwdata;
                end
                REQ: if (bus.dn_ack) begin
                    state      <= bus.dn_err ? ERR1 : RESP;
                    bus.hready <= ~bus.dn_err;
                    bus.hresp  <= bus.dn_err ? ERROR : OKAY;
                    bus.dn_req <= 1'b0;
                    if (!bus.dn_we) bus.hrdata <= bus.dn_rdata;
                end
                ERR1: begin
                    state      <= ERR2;
                    bus.hready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    bus.hready <= 1'b1;
                    bus.hresp  <= OKAY;
                end
            endcase
        end
    end
`ifdef ADDR_FILTER_STATS_EN
    always_ff @(posedge hclk) begin
        if (hreset) begin
            stat_pass  <= '0;
            stat_block <= '0;
        end else if (capture) begin
            if (pass & ~&stat_pass) stat_pass <= stat_pass + 1'b1;
            if (~pass & ~&stat_block) stat_block <= stat_block + 1'b1;
        end
    end
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif
endmodule

// File: tb/tb_ahb_addr_filter_slv.sv
// tb_ahb_addr_filter_slv: directed transfers checked each cycle against a transaction-level model.
module tb_ahb_addr_filter_slv;
    localparam int AW = 32, DW = 32, NW = 4, CW = 16;
    typedef struct {
        logic [31:0] addr; logic [2:0] size; logic we; logic seq;
        logic [31:0] wdata; int delay; logic err; logic [31:0] rdata;
    } txn_t;
    typedef struct {
        logic rdy; logic [1:0] resp; logic req; logic ack; logic err; logic [31:0] rdata;
        logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
    } cyc_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    ahb_addr_filter_slv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [NW*AW-1:0] cfg_base, cfg_mask;
    logic [NW-1:0]    cfg_en;
`ifdef ADDR_FILTER_STATS_EN
    logic [CW-1:0] stat_pass, stat_block;
`endif

    ahb_addr_filter_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WIN(NW), .CNT_WIDTH(CW)) dut (
        .hclk(clk), .hreset(rst), .bus(bus), .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_en(cfg_en)
`ifdef ADDR_FILTER_STATS_EN
        , .stat_pass(stat_pass), .stat_block(stat_block)
`endif
    );

    int total = 0, bad = 0;
    cyc_t exp_q[$];
    cyc_t cur = '{rdy: 1'b1, default: '0};
    txn_t pend;
    bit chk_en = 0;
    logic [31:0] m_hrdata = '0;
    int m_pass_n = 0, m_block_n = 0, cap_cnt = 0;
    int req_n = 0, lo_n = 0, err_n = 0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [3:0] s_be = '0;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        for (int w = 0; w < NW; w++)
            if (cfg_en[w] && (((a ^ cfg_base[w*AW +: AW]) & cfg_mask[w*AW +: AW]) == 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_ok(input txn_t t);
        return m_hit(t.addr) && t.size <= 3'd2 && (t.addr % (32'd1 << t.size)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input txn_t t);
        int bytes = 1 << t.size;
        return 4'(((1 << bytes) - 1) << t.addr[1:0]);
    endfunction

    function automatic txn_t mk(input logic [31:0] a, input logic [2:0] sz, input logic we, input logic seq,
                                input logic [31:0] wd, input int dly, input logic er, input logic [31:0] rd);
        txn_t t;
        t.addr = a; t.size = sz; t.we = we; t.seq = seq; t.wdata = wd; t.delay = dly; t.err = er; t.rdata = rd;
        return t;
    endfunction

    // Model: a captured transfer expands into the list of data-phase cycles it must produce.
    always @(posedge clk) begin
        cyc_t c, e;
        if (rst) begin
            exp_q.delete();
            chk_en = 1;
            m_hrdata = '0;
            m_pass_n = 0;
            m_block_n = 0;
        end else begin
            if (cur.ack && !cur.we) m_hrdata = cur.rdata;
            if (cur.rdy && bus.hsel && bus.htrans[1]) begin
                cap_cnt++;
                c = '{default: '0};
                e = '{default: '0};
                e.resp = 2'b01;
                if (m_ok(pend)) begin
                    m_pass_n++;
                    exp_q.push_back(c);
                    for (int k = 0; k <= pend.delay; k++) begin
                        c.req = 1; c.addr = pend.addr; c.we = pend.we; c.be = m_be(pend); c.wdata = pend.wdata;
                        c.ack = (k == pend.delay); c.err = pend.err; c.rdata = pend.rdata;
                        exp_q.push_back(c);
                    end
                    c = '{default: '0};
                    c.rdy = 1;
                    if (pend.err) begin
                        exp_q.push_back(e);
                        e.rdy = 1;
                        exp_q.push_back(e);
                    end else exp_q.push_back(c);
                end else begin
                    m_block_n++;
                    exp_q.push_back(e);
                    e.rdy = 1;
                    exp_q.push_back(e);
                end
            end
        end
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else begin
            cur = '{default: '0};
            cur.rdy = 1;
        end
        #1;
        bus.dn_ack = cur.ack;
        bus.dn_err = cur.ack & cur.err;
        bus.dn_rdata = cur.ack ? cur.rdata : 32'h5A5A_5A5A;
    end

    always @(negedge clk) if (chk_en) begin
        check("hready", 32'(bus.hready), 32'(cur.rdy));
        check("hresp", 32'(bus.hresp), 32'(cur.resp));
        check("dn_req", 32'(bus.dn_req), 32'(cur.req));
        check("hrdata", bus.hrdata, m_hrdata);
        if (cur.req) begin
            check("dn_addr", bus.dn_addr, cur.addr);
            check("dn_we", 32'(bus.dn_we), 32'(cur.we));
            check("dn_be", 32'(bus.dn_be), 32'(cur.be));
            if (cur.we) check("dn_wdata", bus.dn_wdata, cur.wdata);
        end
`ifdef ADDR_FILTER_STATS_EN
        check("stat_pass", 32'(stat_pass), 32'(m_pass_n));
        check("stat_block", 32'(stat_block), 32'(m_block_n));
`endif
        if (bus.dn_req) begin
            req_n++;
            s_addr = bus.dn_addr;
            s_be = bus.dn_be;
            s_wdata = bus.dn_wdata;
        end
        if (!bus.hready) lo_n++;
        if (bus.hresp == 2'b01) err_n++;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input txn_t t);
        int n = 0;
        int c0 = cap_cnt;
        pend = t;
        bus.hsel = 1'b1; bus.htrans = t.seq ? 2'b11 : 2'b10;
        bus.haddr = t.addr; bus.hsize = t.size; bus.hwrite = t.we;
        while (cap_cnt == c0 && n < 40) begin @(posedge clk); #1; n++; end
        if (cap_cnt == c0) begin
            total++; bad++;
            $display("FAIL capture_timeout: got no capture expected capture at %0t", $time);
        end
        bus.hwdata = t.wdata;
        bus.hsel = 1'b0; bus.htrans = 2'b00;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got %0d pending expected 0 at %0t", exp_q.size(), $time);
        end
        step(1);
    endtask

    int r0, l0, e0;
    task automatic snap();
        r0 = req_n; l0 = lo_n; e0 = err_n;
    endtask

    initial begin
        bus.hsel = 0; bus.htrans = 0; bus.hburst = 3'b001; bus.hsize = 0; bus.hwrite = 0;
        bus.haddr = 0; bus.hwdata = 0; bus.dn_ack = 0; bus.dn_rdata = 0; bus.dn_err = 0;
        cfg_base = '0; cfg_mask = '0; cfg_en = 4'b0001;
        cfg_base[0 +: AW] = 32'h1000_0000; cfg_mask[0 +: AW] = 32'hFFFF_0000;
        step(3);
        rst = 1'b0;
        check("rst_hready", 32'(bus.hready), 32'd1);
        check("rst_hresp", 32'(bus.hresp), 32'd0);
        check("rst_hrdata", bus.hrdata, 32'd0);
        check("rst_dn_req", 32'(bus.dn_req), 32'd0);
        check("rst_dn_addr", bus.dn_addr, 32'd0);
        check("rst_dn_be", 32'(bus.dn_be), 32'd0);
        check("rst_dn_wdata", bus.dn_wdata, 32'd0);
        check("rst_dn_we", 32'(bus.dn_we), 32'd0);
        step(1);
        // word write inside window 0
        snap();
        issue(mk(32'h1000_0010, 3'd2, 1, 0, 32'hDEAD_BEEF, 0, 0, 0));
        wait_done();
        check("wr_req_cycles", 32'(req_n - r0), 32'd1);
        check("wr_dn_addr", s_addr, 32'h1000_0010);
        check("wr_dn_be", 32'(s_be), 32'hF);
        check("wr_dn_wdata", s_wdata, 32'hDEAD_BEEF);
        check("wr_wait_cycles", 32'(lo_n - l0), 32'd2);
        // outside every window
        snap();
        issue(mk(32'h2000_0000, 3'd2, 0, 0, 0, 0, 0, 0));
        wait_done();
        check("blk_req_cycles", 32'(req_n - r0), 32'd0);
        check("blk_err_cycles", 32'(err_n - e0), 32'd2);
        check("blk_wait_cycles", 32'(lo_n - l0), 32'd1);
        // misaligned half, then a legal byte at the same address
        snap();
        issue(mk(32'h1000_0003, 3'd1, 0, 0, 0, 0, 0, 0));
        wait_done();
        check("half_err_cycles", 32'(err_n - e0), 32'd2);
        check("half_req_cycles", 32'(req_n - r0), 32'd0);
        issue(mk(32'h1000_0003, 3'd0, 0, 0, 0, 0, 0, 32'h1122_3344));
        wait_done();
        check("byte_dn_be", 32'(s_be), 32'b1000);
        check("byte_hrdata", bus.hrdata, 32'h1122_3344);
        issue(mk(32'h1000_0000, 3'd3, 0, 0, 0, 0, 0, 0));
        wait_done();
        // slow downstream with error
        snap();
        issue(mk(32'h1000_0100, 3'd2, 0, 0, 0, 5, 1, 32'hCAFE_0001));
        wait_done();
        check("slow_req_cycles", 32'(req_n - r0), 32'd6);
        check("slow_err_cycles", 32'(err_n - e0), 32'd2);
        check("slow_wait_cycles", 32'(lo_n - l0), 32'd8);
        // back-to-back burst: each next address waits for the RESP cycle
        snap();
        issue(mk(32'h1000_0020, 3'd2, 1, 0, 32'h1111_1111, 0, 0, 0));
        issue(mk(32'h1000_0024, 3'd2, 1, 1, 32'h2222_2222, 0, 0, 0));
        issue(mk(32'h1000_0028, 3'd2, 0, 1, 0, 1, 0, 32'h3333_3333));
        wait_done();
        check("b2b_req_cycles", 32'(req_n - r0), 32'd4);
        check("b2b_wait_cycles", 32'(lo_n - l0), 32'd7);
        check("b2b_hrdata", bus.hrdata, 32'h3333_3333);
        // BUSY and unselected NONSEQ must not capture
        bus.hsel = 1; bus.htrans = 2'b01; bus.haddr = 32'h1000_0000;
        step(2);
        bus.hsel = 0; bus.htrans = 2'b10;
        step(2);
        bus.htrans = 2'b00;
        // second window, config dropped after capture
        cfg_en = 4'b0011;
        cfg_base[AW +: AW] = 32'h4000_0000; cfg_mask[AW +: AW] = 32'hFFFF_FF00;
        snap();
        issue(mk(32'h4000_0081, 3'd0, 1, 0, 32'h0000_AB00, 2, 0, 0));
        cfg_en = 4'b0000;
        wait_done();
        check("win1_dn_be", 32'(s_be), 32'b0010);
        check("win1_err_cycles", 32'(err_n - e0), 32'd0);
        issue(mk(32'h1000_0000, 3'd2, 0, 0, 0, 0, 0, 0));
        wait_done();
        cfg_en = 4'b0001;
        // reset while the request is outstanding
        issue(mk(32'h1000_0040, 3'd2, 0, 0, 0, 20, 0, 32'h7777_7777));
        step(2);
        rst = 1'b1;
        step(1);
        check("rreq_dn_req", 32'(bus.dn_req), 32'd0);
        check("rreq_hready", 32'(bus.hready), 32'd1);
        check("rreq_hresp", 32'(bus.hresp), 32'd0);
        rst = 1'b0;
        step(1);
        snap();
        issue(mk(32'h1000_0044, 3'd1, 1, 0, 32'h0000_BEEF, 0, 0, 0));
        wait_done();
        check("post_rst_req_cycles", 32'(req_n - r0), 32'd1);
        check("post_rst_dn_addr", s_addr, 32'h1000_0044);
        check("post_rst_dn_be", 32'(s_be), 32'b0011);
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_addr_filter_slv.md
Name: ahb_addr_filter_slv

Overview:
AHB-lite slave that sits directly downstream of the AHB master agent/bus: it consumes the master's address/data phases, checks each transfer against NUM_WIN programmable address windows, and checks size/alignment. Allowed transfers are forwarded as single-beat requests on a simple req/ack downstream port. Blocked or misaligned transfers receive a two-cycle AHB ERROR response without any downstream activity. The block is the sole slave on the bus and drives hready directly.

Parameters:
ADDR_WIDTH, 32, haddr/dn_addr width
DATA_WIDTH, 32, data width; fixed at 32 for byte-enable logic
NUM_WIN, 4, number of address windows
CNT_WIDTH, 16, statistics counter width (used only with ADDR_FILTER_STATS_EN)

Ports:
hclk  in  1  clock
hreset  in  1  synchronous reset, active-high
hsel  in  1  slave select
htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hburst  in  3  ignored; every beat is decoded independently
hsize  in  3  0=byte, 1=half, 2=word, >2 illegal
hwrite  in  1  1=write
haddr  in  ADDR_WIDTH  address
hwdata  in  DATA_WIDTH  write data, valid in data phase
hready  out  1  transfer done / slave ready
hresp  out  2  00=OKAY, 01=ERROR
hrdata  out  DATA_WIDTH  read data
cfg_base  in  NUM_WIN*ADDR_WIDTH  window bases, window i at [i*ADDR_WIDTH +: ADDR_WIDTH]
cfg_mask  in  NUM_WIN*ADDR_WIDTH  window masks, same packing
cfg_en  in  NUM_WIN  per-window enable
dn_req  out  1  downstream request, held until ack
dn_we  out  1  downstream write
dn_addr  out  ADDR_WIDTH  downstream address
dn_wdata  out  DATA_WIDTH  downstream write data
dn_be  out  4  byte enables
dn_ack  in  1  downstream accept/complete, single-cycle
dn_rdata  in  DATA_WIDTH  read data, valid with dn_ack
dn_err  in  1  downstream error, valid with dn_ack

Behaviour:
- Reset (hreset=1 at a posedge): state IDLE. Outputs: hready=1, hresp=00, hrdata=0, dn_req=0, dn_we=0, dn_addr=0, dn_wdata=0, dn_be=0. Reset mid-transfer drops dn_req on the next clock with no handshake completion; the downstream must tolerate an abandoned request.
- Address capture: occurs when hsel & hready & htrans[1] at a posedge. IDLE/BUSY, or hsel=0: no capture, zero-wait OKAY.
- Decode uses values sampled at capture. cfg_* changes afterwards do not affect that transfer.
  - hit = OR over i of cfg_en[i] & ((haddr & mask_i) == (base_i & mask_i)). cfg_en=0 means every address is blocked.
  - misaligned = hsize>2 | (hsize==1 & haddr[0]) | (hsize==2 & haddr[1:0]!=0).
  - pass = hit & !misaligned.
- dn_be (little-endian): byte gives 1<<haddr[1:0]; half gives 0011 or 1100 by haddr[1]; word gives 1111.
- FSM:
  - IDLE: hready=1. Capture with pass goes to CAPT; capture with !pass goes to ERR1.
  - CAPT: the data-phase cycle. hready=0. hwdata is sampled at the end of this cycle. Next state is REQ.
  - REQ: dn_req=1, dn_addr/dn_we/dn_be/dn_wdata stable, hready=0. Stays in REQ until dn_ack. On dn_ack, dn_rdata is registered into hrdata (reads only) and dn_req falls on the next clock. dn_ack&!dn_err goes to RESP; dn_ack&dn_err goes to ERR1.
  - RESP: hready=1, hresp=OKAY. A new capture goes to CAPT or ERR1; otherwise IDLE.
  - ERR1: hready=0, hresp=ERROR. Next state is ERR2.
  - ERR2: hready=1, hresp=ERROR. A new capture goes to CAPT or ERR1; otherwise IDLE.
- Latency:
  - Passing transfer, ack in the first REQ cycle: data phase is 3 cycles (CAPT, REQ, RESP).
  - Each extra cycle without ack adds one wait state.
  - Blocked transfer: 2 cycles, with zero downstream activity.
- hrdata holds its last value outside RESP and is unchanged by writes.
- dn_ack outside REQ is ignored.

Optional Feature:
Macro ADDR_FILTER_STATS_EN.
- Defined: adds outputs stat_pass (CNT_WIDTH) and stat_block (CNT_WIDTH).
  - stat_pass increments on each capture with pass.
  - stat_block increments on each capture with !pass.
  - Both are saturating at all-ones, cleared by hreset, and do not count dn_err.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- cfg_en=0001, base0=0x1000_0000, mask0=0xFFFF_0000. NONSEQ word write 0x1000_0010, hwdata=0xDEAD_BEEF, dn_ack in the first REQ cycle -> dn_req 1 cycle with dn_addr=0x1000_0010, dn_be=1111, dn_wdata=0xDEAD_BEEF; hready low 2 cycles then high with OKAY.
- Same config, word read 0x2000_0000 -> hresp ERROR with hready 0 then 1; dn_req never asserted; stat_block=1 if enabled.
- Half read 0x1000_0003 -> misaligned, ERROR response. Byte read 0x1000_0003 -> dn_be=1000, hrdata=dn_rdata=0x1122_3344.
- Read with dn_ack delayed 5 cycles, dn_err=1 -> dn_req held 6 cycles, then two-cycle ERROR.
- Back-to-back NONSEQ/SEQ pass transfers with next address presented during RESP -> second capture taken in RESP; no idle cycle; each beat completes OKAY.
- hreset=1 while in REQ -> next cycle dn_req=0, hready=1, hresp=00; a subsequent transfer completes normally.
